mem_handler: RTL and testbench
==============================

Name: mem_handler

Overview:
- Sits between the RV32I core's load/store and fetch logic and the 4096-word single-cycle-registered RAM.
- Converts byte-addressed, sized CPU data requests into word-addressed RAM accesses.
- Performs read-modify-write for SB/SH, and byte/halfword extraction with sign/zero extension for loads.
- Drives a stall/done handshake back to the core; the instruction path is a thin address translation alongside.

Parameters:
- RAM_ADDR_W, 12, word-address width of the RAM; word index = addr[RAM_ADDR_W+1:2].
- CHECK_RANGE, 1, when 1, any nonzero addr bits above RAM_ADDR_W+1 flag an error.

Ports:
- clk  in  1  system clock
- nrst  in  1  synchronous active-low reset
- instr_addr  in  32  byte address of fetch
- data_addr  in  32  byte address of load/store
- data_read  in  1  load request, held until done
- data_write  in  1  store request, held until done
- funct3  in  3  RV32I size/sign code
- store_data  in  32  store value, right-aligned
- instr  out  32  fetched instruction
- instr_misaligned  out  1  instr_addr[1:0] != 0
- load_data  out  32  extended load result
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; access rejected
- stall  out  1  request pending and not completing this cycle
- ram_addr_data  out  RAM_ADDR_W  RAM data word address
- ram_addr_instr  out  RAM_ADDR_W  RAM instruction word address
- ram_data_in  out  32  RAM write word
- ram_we  out  1  RAM write enable
- ram_data_out  in  32  RAM registered data read, previous-cycle address
- ram_instr_out  in  32  RAM registered instruction read

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, nrst).
- Reset values: state IDLE, load_data 0, done 0, error 0; latched addr/funct3/data cleared.
- ram_we is forced 0 whenever nrst=0, including mid-operation.
- Instruction path (combinational):
  - ram_addr_instr = instr_addr[RAM_ADDR_W+1:2].
  - instr = ram_instr_out; fetch latency is one cycle, owned by the core.
- Accept in IDLE: if data_read or data_write, latch data_addr, funct3, store_data. All later cycles use the latched copy; core changes to inputs mid-op are ignored.
- Error checks (evaluated on accept):
  - read and write both high;
  - funct3 not legal: loads 000/001/010/100/101, stores 000/001/010;
  - halfword with addr[0]=1;
  - word with addr[1:0] != 0;
  - out of range when CHECK_RANGE=1.
  - On error: go to DONE with error=1, ram_we=0, load_data unchanged.
- States:
  - IDLE: drive ram_addr_data from the live data_addr.
    - SW: ram_we=1, ram_data_in=store_data, go to DONE.
    - Load: go to LOAD_WAIT.
    - SB/SH: go to RMW_WAIT.
  - LOAD_WAIT: ram_data_out is valid.
    - Register load_data from the lane selected by latched addr[1:0]: LB/LBU byte, LH/LHU half at addr[1], LW word.
    - Sign-extend for LB/LH, zero-extend for LBU/LHU.
    - Go to DONE.
  - RMW_WAIT: merge store_data[7:0] or [15:0] into the addressed lane of ram_data_out, ram_we=1, go to DONE.
  - DONE: done=1 for one cycle (error as decided), return to IDLE. A new request can be accepted on the following cycle.
- stall = (data_read | data_write) & (state != DONE).
- Latency from request in cycle N:
  - SW and errors: done at N+1.
  - Loads and SB/SH: done at N+2.
- ram_addr_data holds the latched word address in every state other than IDLE.
- Read-during-write to the same RAM word returns old data; the RMW ordering never depends on this.
- Reset asserted in LOAD_WAIT/RMW_WAIT: no write issued, no done pulse, IDLE next cycle.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, LOAD_WAIT, RMW_WAIT, DONE};
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One combinational sub-module, byte_lane_unit, provides load extract/extend and store merge, keyed by funct3 and addr[1:0].

Test Plan:
- RAM word 4 = 0x8BADF00D; LB 0x13 -> load_data 0xFFFFFF8B, done at N+2, stall high N..N+1, error 0.
- LBU 0x12 -> 0x000000AD; LHU 0x10 -> 0x0000F00D; LH 0x12 -> 0xFFFF8BAD.
- SB 0x11 data 0xFFFFFFAA -> single ram_we at N+1 with ram_data_in 0x8BADAA0D; subsequent LW 0x10 returns 0x8BADAA0D.
- SW 0x20 data 0x12345678 -> ram_we at N, ram_addr_data 8, done at N+1; LW 0x20 returns 0x12345678.
- Error cases, each with done and error at N+1 and no ram_we: LW 0x22 (misaligned); data_addr 0x00010000 (range); funct3 011; read and write both high.
- nrst low during RMW_WAIT of SB 0x10 -> ram_we stays 0, word 4 unchanged, no done, IDLE after release.

Source files
------------

// File: rtl/mem_handler_pkg.sv
// mem_pkg: shared types for the data-memory handler.
// Holds the handler FSM state encoding and the RV32I funct3 size codes.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WAIT  = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_handler_if.sv
// mem_handler_if: core <-> handler data request/response bundle.
// master = core (drives the request); slave = mem_handler (drives the response).
interface mem_handler_if;
    logic [31:0] data_addr;
    logic        data_read;
    logic        data_write;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        done;
    logic        error;
    logic        stall;

    modport master (
        output data_addr, data_read, data_write, funct3, store_data,
        input  load_data, done, error, stall
    );

    modport slave (
        input  data_addr, data_read, data_write, funct3, store_data,
        output load_data, done, error, stall
    );
endinterface

// File: rtl/mem_handler_byte_lane_unit.sv
// byte_lane_unit: combinational load extract/extend and store lane merge.
// Ports: i_funct3, i_addr_lo (byte offset), i_rdata (RAM word), i_wdata
// (right-aligned store value), o_load_val (extended load), o_merged (RMW word).
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_val,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load_val = i_rdata;
        case (i_funct3)
            F3_B:    o_load_val = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_val = {24'd0, w_byte};
            F3_H:    o_load_val = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_val = {16'd0, w_half};
            default: o_load_val = i_rdata;
        endcase
    end

    always_comb begin
        o_merged = i_rdata;
        case (i_funct3)
            F3_B: o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_addr_lo[1])
                    o_merged[31:16] = i_wdata;
                else
                    o_merged[15:0] = i_wdata;
            end
            default: o_merged = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_handler.sv
// mem_handler: byte-addressed sized core requests -> word-addressed RAM.
// Ports: clk, nrst (sync active-low), instr_addr/instr/instr_misaligned
// (fetch), bus (core data handshake), ram_* (RAM word interface).
module mem_handler
    import mem_pkg::*;
#(
    parameter int RAM_ADDR_W  = 12,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [31:0]           instr_addr,
    output logic [31:0]           instr,
    output logic                  instr_misaligned,
    mem_handler_if.slave          bus,
    output logic [RAM_ADDR_W-1:0] ram_addr_data,
    output logic [RAM_ADDR_W-1:0] ram_addr_instr,
    output logic [31:0]           ram_data_in,
    output logic                  ram_we,
    input  logic [31:0]           ram_data_out,
    input  logic [31:0]           ram_instr_out
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_LOAD = LOAD_WAIT;
    localparam logic [1:0] S_RMW  = RMW_WAIT;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]            r_state;
    logic [RAM_ADDR_W+1:0] r_addr;
    logic [2:0]            r_f3;
    logic [15:0]           r_data;
    logic                  r_err;
    logic [31:0]           r_load;

    logic [1:0]  w_next;
    logic        w_req;
    logic        w_err;
    logic        w_f3_ok;
    logic        w_misal;
    logic        w_oor;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;
    logic        w_unused;

    // Instruction path: pure address translation, RAM owns the latency.
    assign ram_addr_instr   = instr_addr[RAM_ADDR_W+1:2];
    assign instr            = ram_instr_out;
    assign instr_misaligned = |instr_addr[1:0];
    assign w_unused         = ^instr_addr[31:RAM_ADDR_W+2];

    assign w_req = bus.data_read | bus.data_write;

    // Request validation on the live inputs, used only at accept time.
    always_comb begin
        w_f3_ok = 1'b0;
        if (bus.data_read && !bus.data_write)
            w_f3_ok = bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        else if (bus.data_write && !bus.data_read)
            w_f3_ok = bus.funct3 inside {F3_B, F3_H, F3_W};

        w_misal = 1'b0;
        if (bus.funct3 == F3_H || bus.funct3 == F3_HU)
            w_misal = bus.data_addr[0];
        else if (bus.funct3 == F3_W)
            w_misal = |bus.data_addr[1:0];

        w_oor = CHECK_RANGE &&
                ((bus.data_addr >> (RAM_ADDR_W + 2)) != 32'd0);

        w_err = (bus.data_read && bus.data_write) || !w_f3_ok ||
                w_misal || w_oor;
    end

    byte_lane_unit u_lanes (
        .i_funct3   (r_f3),
        .i_addr_lo  (r_addr[1:0]),
        .i_rdata    (ram_data_out),
        .i_wdata    (r_data),
        .o_load_val (w_load_val),
        .o_merged   (w_merged)
    );

    // Live address in IDLE so the RAM read starts on the accept cycle.
    assign ram_addr_data = (r_state == S_IDLE) ?
                           bus.data_addr[RAM_ADDR_W+1:2] :
                           r_addr[RAM_ADDR_W+1:2];

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_wdata = w_merged;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_err) begin
                        w_next = S_DONE;
                    end else if (bus.data_write) begin
                        if (bus.funct3 == F3_W) begin
                            w_we    = 1'b1;
                            w_wdata = bus.store_data;
                            w_next  = S_DONE;
                        end else begin
                            w_next = S_RMW;
                        end
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: w_next = S_DONE;
            S_RMW: begin
                w_we   = 1'b1;
                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Reset gates the write strobe even mid-RMW.
    assign ram_we      = w_we & nrst;
    assign ram_data_in = w_wdata;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_f3    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_load  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req) begin
                r_addr <= bus.data_addr[RAM_ADDR_W+1:0];
                r_f3   <= bus.funct3;
                r_data <= bus.store_data[15:0];
                r_err  <= w_err;
            end
            if (r_state == S_LOAD)
                r_load <= w_load_val;
        end
    end

    assign bus.done      = (r_state == S_DONE);
    assign bus.error     = (r_state == S_DONE) & r_err;
    assign bus.stall     = w_req & (r_state != S_DONE);
    assign bus.load_data = r_load;

endmodule

// File: tb/tb_mem_handler.sv
// tb_mem_handler: randomized self-checking bench for mem_handler.
// A word-array reference model predicts results, latency and RAM writes.
module tb_mem_handler;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] instr_addr = '0;
    logic [31:0] instr;
    logic        instr_misaligned;
    logic [11:0] ram_addr_data;
    logic [11:0] ram_addr_instr;
    logic [31:0] ram_data_in;
    logic        ram_we;
    logic [31:0] ram_data_out;
    logic [31:0] ram_instr_out;

    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    logic [31:0] ram     [4096];
    logic [31:0] ref_mem [4096];
    logic [31:0] exp_ld;
    logic [31:0] last_we_addr;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_handler_if bus ();

    mem_handler #(
        .RAM_ADDR_W  (12),
        .CHECK_RANGE (1'b1)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .instr_addr       (instr_addr),
        .instr            (instr),
        .instr_misaligned (instr_misaligned),
        .bus              (bus.slave),
        .ram_addr_data    (ram_addr_data),
        .ram_addr_instr   (ram_addr_instr),
        .ram_data_in      (ram_data_in),
        .ram_we           (ram_we),
        .ram_data_out     (ram_data_out),
        .ram_instr_out    (ram_instr_out)
    );

    // Registered-read RAM; read-during-write returns old data.
    always @(posedge clk) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (ram_we)
            ram[ram_addr_data] <= ram_data_in;
        ram_data_out  <= ram[ram_addr_data];
        ram_instr_out <= ram[ram_addr_instr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at #1 after a posedge with the DUT idle; returns likewise.
    task automatic do_op(input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit scr);
        int          idx, sh, lat, we_cyc, got_lat, got_we_cyc, n_we;
        bit          err;
        logic [31:0] old, nw, v, mask, we_addr, we_data;
        idx  = int'(addr[13:2]);
        old  = ref_mem[idx];
        sh   = 8 * int'(addr[1:0]);
        err  = 1'b0;
        if (rd && wr)   err = 1'b1;
        else if (rd)    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else            err = !(f3 inside {3'd0, 3'd1, 3'd2});
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) err = 1'b1;
        if (f3 == 3'd2 && addr[1:0] != 2'd0)      err = 1'b1;
        if ((addr >> 14) != 32'd0)                err = 1'b1;
        we_cyc = -1;
        nw     = old;
        if (err) begin
            lat = 1;
        end else if (wr && f3 == 3'd2) begin
            lat = 1; we_cyc = 0; nw = wd;
        end else if (wr) begin
            lat = 2; we_cyc = 1;
            mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
            nw = (old & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            lat = 2;
            v = old >> sh;
            case (f3)
                3'd0: begin v &= 32'hFF;   if (v[7])  v |= 32'hFFFFFF00; end
                3'd4: v &= 32'hFF;
                3'd1: begin v &= 32'hFFFF; if (v[15]) v |= 32'hFFFF0000; end
                3'd5: v &= 32'hFFFF;
                default: v = old;
            endcase
            exp_ld = v;
        end

        bus.data_read  = rd;
        bus.data_write = wr;
        bus.funct3     = f3;
        bus.data_addr  = addr;
        bus.store_data = wd;
        got_lat = -1; got_we_cyc = -1; n_we = 0;
        we_addr = '0; we_data = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ram_we) begin
                n_we++; got_we_cyc = c;
                we_addr = 32'(ram_addr_data); we_data = ram_data_in;
            end
            if (bus.done) begin
                got_lat = c;
                break;
            end
            chk("stall_pending", 32'(bus.stall), 32'd1);
            @(posedge clk); #1;
            if (scr) begin
                bus.data_addr  = $urandom;
                bus.funct3     = 3'($urandom);
                bus.store_data = $urandom;
            end
        end
        chk("latency", got_lat, lat);
        chk("we_count", n_we, (we_cyc >= 0) ? 1 : 0);
        chk("we_cycle", got_we_cyc, we_cyc);
        if (we_cyc >= 0) begin
            chk("we_addr", we_addr, idx);
            chk("we_data", we_data, nw);
            ref_mem[idx] = nw;
            last_we_addr = we_addr;
        end
        if (got_lat >= 0) begin
            chk("error", 32'(bus.error), 32'(err));
            chk("load_data", bus.load_data, exp_ld);
            chk("stall_done", 32'(bus.stall), 32'd0);
        end
        @(posedge clk); #1;
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
    endtask

    task automatic chk_fetch(input logic [31:0] addr);
        instr_addr = addr;
        @(negedge clk);
        chk("instr_ram_addr", 32'(ram_addr_instr), 32'(addr[13:2]));
        chk("instr_misal", 32'(instr_misaligned), 32'(addr[1:0] != 2'd0));
        @(posedge clk);
        @(negedge clk);
        chk("instr", instr, ref_mem[int'(addr[13:2])]);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        bus.funct3     = '0;
        bus.data_addr  = '0;
        bus.store_data = '0;
        exp_ld         = '0;
        last_we_addr   = '0;
        pl_en          = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pl_addr = 12'(i);
            pl_data = (i == 4) ? 32'h8BADF00D : $urandom;
            ref_mem[i] = pl_data;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        @(negedge clk);
        chk("rst_load_data", bus.load_data, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        do_op(1, 0, 3'd0, 32'h13, 32'h0, 0);
        chk("lb_13", bus.load_data, 32'hFFFFFF8B);
        do_op(1, 0, 3'd4, 32'h12, 32'h0, 1);
        chk("lbu_12", bus.load_data, 32'h000000AD);
        do_op(1, 0, 3'd5, 32'h10, 32'h0, 0);
        chk("lhu_10", bus.load_data, 32'h0000F00D);
        do_op(1, 0, 3'd1, 32'h12, 32'h0, 0);
        chk("lh_12", bus.load_data, 32'hFFFF8BAD);
        do_op(0, 1, 3'd0, 32'h11, 32'hFFFFFFAA, 1);
        do_op(1, 0, 3'd2, 32'h10, 32'h0, 0);
        chk("lw_after_sb", bus.load_data, 32'h8BADAA0D);
        do_op(0, 1, 3'd2, 32'h20, 32'h12345678, 0);
        chk("sw_addr", last_we_addr, 32'd8);
        do_op(1, 0, 3'd2, 32'h20, 32'h0, 0);
        chk("lw_after_sw", bus.load_data, 32'h12345678);
        do_op(1, 0, 3'd2, 32'h22, 32'h0, 0);
        do_op(1, 0, 3'd2, 32'h00010000, 32'h0, 0);
        do_op(1, 0, 3'd3, 32'h10, 32'h0, 0);
        do_op(1, 1, 3'd2, 32'h10, 32'h0, 0);
        chk("ld_kept_on_err", bus.load_data, 32'h12345678);

        // Reset while in RMW_WAIT: write must be suppressed.
        bus.data_write = 1'b1;
        bus.funct3     = 3'd0;
        bus.data_addr  = 32'h10;
        bus.store_data = 32'h55;
        @(negedge clk);
        chk("rmw_rst_stall", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        nrst = 1'b0;
        @(negedge clk);
        chk("rmw_rst_we", 32'(ram_we), 32'd0);
        chk("rmw_rst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        bus.data_write = 1'b0;
        exp_ld = '0;
        @(negedge clk);
        chk("post_rst_done", 32'(bus.done), 32'd0);
        chk("post_rst_ld", bus.load_data, 32'd0);
        chk("post_rst_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        do_op(1, 0, 3'd2, 32'h10, 32'h0, 0);
        chk("word4_kept", bus.load_data, 32'h8BADAA0D);

        chk_fetch(32'h10);
        chk_fetch(32'h22);
        chk_fetch(32'h7C);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0)
                a = a | (32'd1 << $urandom_range(14, 31));
            do_op((r <= 5) ? 1'b1 : 1'b0, (r == 0 || r >= 6) ? 1'b1 : 1'b0,
                  3'($urandom), a, $urandom, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
